// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//   Off-chip data memory model sitting on the responder side of the 256-bit
//   line interface driven by dcache_top. A request is accepted from IDLE,
//   waits a fixed LATENCY, then completes with a one-cycle ack. Only one
//   request is ever in flight. The array itself is never reset; its contents
//   are expected to be preloaded externally.
//
// Parameters
//   DEPTH    number of 256-bit lines (power of 2, >= 2)
//   LATENCY  cycles from request acceptance to ack_o (>= 1)
//
// Ports
//   clk_i     in   1    rising-edge clock
//   rst_i     in   1    synchronous reset, active-low
//   addr_i    in   32   byte address of the line; bits [4:0] ignored
//   data_i    in   256  write line data
//   enable_i  in   1    request valid, held by requester until ack_o
//   write_i   in   1    1 = write line, 0 = read line
//   ack_o     out  1    one-cycle completion pulse
//   data_o    out  256  read line data, valid from the ack cycle of a read
//                       and held until the next read completes
// ---------------------------------------------------------------------------
module data_memory_responder #(
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   input  logic         enable_i,
   input  logic         write_i,
   output logic         ack_o,
   output logic [255:0] data_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_idx;
   logic                r_write;
   logic [255:0]        r_wdata;
   logic                r_ack;
   logic [255:0]        r_rdata;
   logic [255:0]        r_mem [DEPTH];

   logic [IDX_W-1:0]    w_idx;
   logic                w_unused_addr;

   // Upper address bits are dropped, so addresses wrap modulo DEPTH lines.
   assign w_idx         = addr_i[IDX_W+4:5];
   assign w_unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

   // Request FSM. ack_o and data_o are registered and get loaded on the
   // transition into DONE, so both are stable for the whole DONE cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (enable_i) begin
                  r_idx   <= w_idx;
                  r_write <= write_i;
                  r_wdata <= data_i;
                  r_cnt   <= CNT_LOAD;
                  if (LATENCY == 1) begin
                     r_state <= S_DONE;
                     r_ack   <= 1'b1;
                     if (!write_i) begin
                        r_rdata <= r_mem[w_idx];
                     end
                  end else begin
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               // Inputs are deliberately ignored here; the request was
               // latched at acceptance and cannot be cancelled.
               r_cnt <= r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) begin
                  r_state <= S_DONE;
                  r_ack   <= 1'b1;
                  if (!r_write) begin
                     r_rdata <= r_mem[r_idx];
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Write commit happens at the edge that ends DONE. Gating with rst_i
   // means a reset arriving during DONE aborts the write.
   always_ff @(posedge clk_i) begin
      if (rst_i && (r_state == S_DONE) && r_write) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   assign ack_o  = r_ack;
   assign data_o = r_rdata;

endmodule
